// File: rtl/audio_clip_sequencer_pkg.sv
// Shared types and sizing for the audio clip sequencer: clip table entry,
// sequencer states and the address/index widths used across the block.
package audio_pkg;

  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned NUM_CLIPS = 8;
  localparam int unsigned IDX_W     = $clog2(NUM_CLIPS);
  localparam int unsigned QDEPTH    = 4;
  localparam int unsigned QCNT_W    = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] stop;
    logic              valid;
  } clip_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    ARM,
    PLAY,
    DONE
  } seq_state_t;

  // An entry is playable when its inclusive range is non-empty (start == stop is one byte).
  function automatic clip_entry_t make_entry(input logic [ADDR_W-1:0] start,
                                             input logic [ADDR_W-1:0] stop);
    clip_entry_t e;
    e.start = start;
    e.stop  = stop;
    e.valid = (stop >= start);
    return e;
  endfunction

endpackage

// File: rtl/audio_clip_sequencer_if.sv
// Player-side bus of the clip sequencer: start pulse, clip range and done level.
interface audio_clip_sequencer_if;
  import audio_pkg::*;

  logic              ply_start;
  logic [ADDR_W-1:0] ply_start_pos;
  logic [ADDR_W-1:0] ply_stop_pos;
  logic              ply_done;

  modport master (
    output ply_start,
    output ply_start_pos,
    output ply_stop_pos,
    input  ply_done
  );

  modport slave (
    input  ply_start,
    input  ply_start_pos,
    input  ply_stop_pos,
    output ply_done
  );

endinterface

// File: rtl/audio_clip_sequencer_fifo.sv
// Play-request FIFO: synchronous push/pop with a flush that empties it in one cycle.
module clip_fifo #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_clip_sequencer.sv
// Replays queued clip indices back-to-back: looks each up in the clip table,
// hands its range to the player, pulses start and waits for the player's done.
module audio_clip_sequencer
  import audio_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [ADDR_W-1:0]      cfg_start,
  input  logic [ADDR_W-1:0]      cfg_stop,
  input  logic                   play_req,
  input  logic [IDX_W-1:0]       play_idx,
  output logic                   play_ack,
  output logic                   q_full,
  output logic [QCNT_W-1:0]      q_count,
  input  logic                   abort,
  audio_clip_sequencer_if.master ply,
  output logic                   busy,
  output logic [IDX_W-1:0]       cur_idx,
  output logic                   clip_done,
  output logic                   err_bad,
  output logic                   err_ovf
);

  seq_state_t        state_q;
  seq_state_t        state_d;
  clip_entry_t       clip_tab [NUM_CLIPS];
  clip_entry_t       head_entry;
  logic [IDX_W-1:0]  head_idx;
  logic              q_empty;
  logic              pop;
  logic              push;
  logic              ovf;
  logic              load_valid;
  logic              load_bad;
  logic [ADDR_W-1:0] start_pos_q;
  logic [ADDR_W-1:0] stop_pos_q;

  assign push = play_req && !abort && (!q_full || pop);
  assign ovf  = play_req && !abort && q_full && !pop;

  clip_fifo #(
    .W     (IDX_W),
    .DEPTH (QDEPTH),
    .CNT_W (QCNT_W)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (play_idx),
    .dout  (head_idx),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Combinational read: a write to the same entry this cycle is not yet visible.
  assign head_entry = clip_tab[head_idx];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < NUM_CLIPS; i++) begin
        clip_tab[i].valid <= 1'b0;
      end
    end else if (cfg_we) begin
      clip_tab[cfg_idx] <= make_entry(cfg_start, cfg_stop);
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load_valid = 1'b0;
    load_bad   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!q_empty) state_d = LOAD;
      end
      LOAD: begin
        if (q_empty) begin
          state_d = IDLE;
        end else begin
          pop = 1'b1;
          if (head_entry.valid) begin
            load_valid = 1'b1;
            state_d    = START;
          end else begin
            load_bad = 1'b1;
            state_d  = (q_count > 3'd1 && !abort) ? LOAD : IDLE;
          end
        end
      end
      START: state_d = ARM;
      // Done may still be high from the previous clip; it is only trusted from PLAY on.
      ARM:   state_d = PLAY;
      PLAY: begin
        if (ply.ply_done) state_d = DONE;
      end
      DONE: begin
        state_d = (!q_empty && !abort) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      play_ack    <= 1'b0;
      err_bad     <= 1'b0;
      err_ovf     <= 1'b0;
      start_pos_q <= '0;
      stop_pos_q  <= '0;
      cur_idx     <= '0;
    end else begin
      state_q  <= state_d;
      play_ack <= push;
      err_bad  <= load_bad;
      if (ovf) begin
        err_ovf <= 1'b1;
      end
      if (load_valid) begin
        start_pos_q <= head_entry.start;
        stop_pos_q  <= head_entry.stop;
        cur_idx     <= head_idx;
      end
    end
  end

  assign ply.ply_start     = (state_q == START);
  assign ply.ply_start_pos = start_pos_q;
  assign ply.ply_stop_pos  = stop_pos_q;
  assign clip_done         = (state_q == DONE);
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Scoreboard bench for audio_clip_sequencer with a behavioural player on the clip bus.
module tb_audio_clip_sequencer;
  import audio_pkg::*;

  logic              clk = 1'b0;
  logic              clr;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_start;
  logic [ADDR_W-1:0] cfg_stop;
  logic              play_req;
  logic [IDX_W-1:0]  play_idx;
  logic              play_ack;
  logic              q_full;
  logic [2:0]        q_count;
  logic              abort;
  logic              busy;
  logic [IDX_W-1:0]  cur_idx;
  logic              clip_done;
  logic              err_bad;
  logic              err_ovf;

  audio_clip_sequencer_if ply();

  audio_clip_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .play_req  (play_req),
    .play_idx  (play_idx),
    .play_ack  (play_ack),
    .q_full    (q_full),
    .q_count   (q_count),
    .abort     (abort),
    .ply       (ply),
    .busy      (busy),
    .cur_idx   (cur_idx),
    .clip_done (clip_done),
    .err_bad   (err_bad),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic              ok;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] stop;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [ADDR_W-1:0] m_start [NUM_CLIPS];
  logic [ADDR_W-1:0] m_stop  [NUM_CLIPS];
  logic              m_valid [NUM_CLIPS];

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned play_len = 6;
  bit          hold_mode = 0;
  int unsigned pcnt = 0;
  int unsigned done_cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned req_cyc = 0;
  bit          chk_req_lat = 0;
  bit          chk_gap = 0;
  bit          in_flight = 0;
  int          n_done = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Player: clears done when started (unless emulating a stale level) and raises it play_len cycles later.
  initial begin
    ply.ply_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ply.ply_start) begin
        ply.ply_done = hold_mode;
        pcnt = hold_mode ? 0 : play_len;
      end else if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) begin
          ply.ply_done = 1'b1;
          done_cyc = cyc;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every start / bad-entry pulse and times the handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (ply.ply_start) begin
        check("start_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("start_entry_valid", mon_e.ok, 1);
          check("start_pos", ply.ply_start_pos, mon_e.start);
          check("stop_pos", ply.ply_stop_pos, mon_e.stop);
          check("cur_idx", cur_idx, mon_e.idx);
        end
        if (chk_req_lat) begin
          check("req_to_start", cyc - req_cyc, 3);
          chk_req_lat = 0;
        end
        if (chk_gap) begin
          check("done_to_start", cyc - done_cyc, 3);
          chk_gap = 0;
        end
        check("start_while_playing", in_flight, 0);
        in_flight = 1;
        start_cyc = cyc;
      end
      if (err_bad) begin
        n_bad++;
        check("bad_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("bad_entry_invalid", mon_e.ok, 0);
        end
      end
      if (clip_done) begin
        n_done++;
        check("clip_done_owed", in_flight, 1);
        in_flight = 0;
        if (hold_mode) check("hold_start_to_done", cyc - start_cyc, 3);
        else           check("done_latency", cyc - done_cyc, 1);
        chk_gap = (sb.size() != 0) && sb[0].ok;
      end
    end
  end

  task automatic cfg(input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] s,
                     input logic [ADDR_W-1:0] e);
    cfg_we = 1'b1; cfg_idx = idx; cfg_start = s; cfg_stop = e;
    @(negedge clk);
    cfg_we = 1'b0;
    m_start[idx] = s;
    m_stop[idx]  = e;
    m_valid[idx] = (e >= s);
  endtask

  task automatic req(input logic [IDX_W-1:0] idx, input logic want_ack);
    exp_t e;
    play_req = 1'b1;
    play_idx = idx;
    if (want_ack) begin
      e.ok = m_valid[idx]; e.idx = idx; e.start = m_start[idx]; e.stop = m_stop[idx];
      sb.push_back(e);
      if (!busy && q_count == 0 && m_valid[idx]) begin
        req_cyc = cyc;
        chk_req_lat = 1;
      end
    end
    @(negedge clk);
    play_req = 1'b0;
    check("play_ack", play_ack, want_ack);
  endtask

  task automatic wait_start(input int unsigned budget);
    int unsigned i = 0;
    while (!ply.ply_start && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("start_seen", ply.ply_start, 1);
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned i = 0;
    while ((busy || q_count != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int b0;
    clr = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_stop = '0;
    play_req = 1'b0; play_idx = '0; abort = 1'b0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      m_valid[i] = 1'b0; m_start[i] = '0; m_stop[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_q_count", q_count, 0);
    check("rst_q_full", q_full, 0);
    check("rst_ack", play_ack, 0);
    check("rst_start", ply.ply_start, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_bad", err_bad, 0);
    check("rst_clip_done", clip_done, 0);
    clr = 1'b0;
    @(negedge clk);

    // Single clip from idle.
    cfg(3'd0, 19'h00100, 19'h001FF);
    req(3'd0, 1'b1);
    check("q_count_after_push", q_count, 1);
    wait_idle(100);

    // Fill the queue behind a long clip; the fifth request is dropped.
    cfg(3'd1, 19'h00200, 19'h002FF);
    cfg(3'd2, 19'h00300, 19'h00300);
    cfg(3'd4, 19'h01000, 19'h7FFFF);
    play_len = 20;
    req(3'd0, 1'b1);
    wait_start(20);
    req(3'd1, 1'b1);
    req(3'd2, 1'b1);
    req(3'd4, 1'b1);
    req(3'd0, 1'b1);
    req(3'd1, 1'b0);
    check("ovf_flag", err_ovf, 1);
    check("full_flag", q_full, 1);
    check("full_count", q_count, 4);
    play_len = 4;
    wait_idle(300);

    // Stale done held high across START/ARM.
    hold_mode = 1;
    req(3'd1, 1'b1);
    wait_idle(100);
    hold_mode = 0;

    // Unconfigured and reversed-range entries are skipped.
    cfg(3'd5, 19'h00020, 19'h00010);
    b0 = n_bad;
    play_len = 10;
    req(3'd0, 1'b1);
    wait_start(20);
    req(3'd3, 1'b1);
    req(3'd5, 1'b1);
    req(3'd1, 1'b1);
    play_len = 4;
    wait_idle(200);
    check("bad_pulses", n_bad - b0, 2);

    // Abort during PLAY with three queued; the request in the abort cycle is discarded.
    play_len = 30;
    req(3'd0, 1'b1);
    wait_start(20);
    req(3'd1, 1'b1);
    req(3'd2, 1'b1);
    req(3'd4, 1'b1);
    check("pre_abort_count", q_count, 3);
    d0 = n_done;
    abort = 1'b1; play_req = 1'b1; play_idx = 3'd1;
    @(negedge clk);
    abort = 1'b0; play_req = 1'b0;
    sb.delete();
    check("abort_q_count", q_count, 0);
    check("abort_req_ack", play_ack, 0);
    check("abort_busy", busy, 1);
    wait_idle(100);
    check("abort_clip_done", n_done - d0, 1);
    check("ovf_sticky", err_ovf, 1);

    // Reset in PLAY abandons the clip and invalidates the table.
    req(3'd2, 1'b1);
    wait_start(20);
    repeat (4) @(negedge clk);
    check("pre_clr_busy", busy, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    pcnt = 0; ply.ply_done = 1'b0; in_flight = 0; chk_gap = 0; sb.delete();
    for (int i = 0; i < NUM_CLIPS; i++) m_valid[i] = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_start", ply.ply_start, 0);
    check("clr_start_pos", ply.ply_start_pos, 0);
    check("clr_stop_pos", ply.ply_stop_pos, 0);
    check("clr_cur_idx", cur_idx, 0);
    check("clr_clip_done", clip_done, 0);
    check("clr_err_ovf", err_ovf, 0);
    check("clr_err_bad", err_bad, 0);
    check("clr_q_count", q_count, 0);
    check("clr_ack", play_ack, 0);
    b0 = n_bad;
    req(3'd0, 1'b1);
    wait_idle(50);
    check("clr_then_bad", n_bad - b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
